// File: rtl/operand_forward_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_forward_stage
// Description : ID/EX register with EX/MEM/WB operand forwarding, XZR rule,
//               load-use bubble insertion and a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_forward_stage #(
    parameter int WIDTH     = 64,
    parameter int REG_BITS  = 5,
    parameter int ZERO_REG  = 31,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [REG_BITS-1:0]  in_rs1,
    input  logic [REG_BITS-1:0]  in_rs2,
    input  logic [REG_BITS-1:0]  in_rd,
    input  logic                 in_regWrite,
    input  logic                 in_memRead,
    input  logic [WIDTH-1:0]     in_rf_data1,
    input  logic [WIDTH-1:0]     in_rf_data2,
    input  logic [WIDTH-1:0]     ex_result,
    input  logic [REG_BITS-1:0]  mem_rd,
    input  logic                 mem_regWrite,
    input  logic [WIDTH-1:0]     mem_result,
    input  logic [REG_BITS-1:0]  wb_rd,
    input  logic                 wb_regWrite,
    input  logic [WIDTH-1:0]     wb_data,
    input  logic                 hold,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_opA,
    output logic [WIDTH-1:0]     out_opB,
    output logic [REG_BITS-1:0]  out_rd,
    output logic                 out_regWrite,
    output logic                 out_memRead,
    output logic                 id_stall,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam logic [REG_BITS-1:0] c_zero_reg = REG_BITS'(ZERO_REG);

    logic                 r_valid;
    logic [WIDTH-1:0]     r_opA;
    logic [WIDTH-1:0]     r_opB;
    logic [REG_BITS-1:0]  r_rd;
    logic                 r_regwrite;
    logic                 r_memread;
    logic [CNT_WIDTH-1:0] r_stall_count;

    logic                 w_ex_src;
    logic                 w_mem_src;
    logic                 w_wb_src;
    logic                 w_hazard;
    logic [REG_BITS-1:0]  w_rs  [2];
    logic [WIDTH-1:0]     w_rf  [2];
    logic [WIDTH-1:0]     w_sel [2];

    // A load in EX has no result yet; it is handled by the bubble instead.
    assign w_ex_src  = r_valid & r_regwrite & ~r_memread & (r_rd != c_zero_reg);
    assign w_mem_src = mem_regWrite & (mem_rd != c_zero_reg);
    assign w_wb_src  = wb_regWrite & (wb_rd != c_zero_reg);

    assign w_rs[0] = in_rs1;
    assign w_rs[1] = in_rs2;
    assign w_rf[0] = in_rf_data1;
    assign w_rf[1] = in_rf_data2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign w_sel[gi] = (w_rs[gi] == c_zero_reg)            ? '0         :
                               (w_ex_src  && r_rd   == w_rs[gi])   ? ex_result  :
                               (w_mem_src && mem_rd == w_rs[gi])   ? mem_result :
                               (w_wb_src  && wb_rd  == w_rs[gi])   ? wb_data    :
                                                                     w_rf[gi];
        end
    endgenerate

    assign w_hazard = in_valid & r_valid & r_memread & r_regwrite &
                      (r_rd != c_zero_reg) & ((r_rd == in_rs1) | (r_rd == in_rs2));

    assign id_stall = ~flush & (hold | w_hazard);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_opA         <= '0;
            r_opB         <= '0;
            r_rd          <= '0;
            r_regwrite    <= 1'b0;
            r_memread     <= 1'b0;
            r_stall_count <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_opA      <= '0;
            r_opB      <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
        end else if (!hold) begin
            if (w_hazard) begin
                r_valid    <= 1'b0;
                r_opA      <= '0;
                r_opB      <= '0;
                r_rd       <= '0;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                if (r_stall_count != '1) begin
                    r_stall_count <= r_stall_count + 1'b1;
                end
            end else begin
                r_valid    <= in_valid;
                r_opA      <= w_sel[0];
                r_opB      <= w_sel[1];
                r_rd       <= in_rd;
                r_regwrite <= in_regWrite & in_valid;
                r_memread  <= in_memRead & in_valid;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_opA      = r_opA;
    assign out_opB      = r_opB;
    assign out_rd       = r_rd;
    assign out_regWrite = r_regwrite;
    assign out_memRead  = r_memread;
    assign stall_count  = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_operand_forward_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_forward_stage
// Description : Directed self-checking bench for operand_forward_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_forward_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid, in_regWrite, in_memRead;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [63:0] in_rf_data1, in_rf_data2, ex_result, mem_result, wb_data;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regWrite, wb_regWrite, hold, flush;

    logic        out_valid, out_regWrite, out_memRead, id_stall;
    logic [63:0] out_opA, out_opB;
    logic [4:0]  out_rd;
    logic [15:0] stall_count;

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    logic        s_valid, s_regWrite, s_memRead, s_id_stall;
    logic [63:0] s_opA, s_opB;
    logic [4:0]  s_rd;
    logic [3:0]  s_stall_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    operand_forward_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_regWrite(in_regWrite), .in_memRead(in_memRead),
        .in_rf_data1(in_rf_data1), .in_rf_data2(in_rf_data2),
        .ex_result(ex_result), .mem_rd(mem_rd), .mem_regWrite(mem_regWrite),
        .mem_result(mem_result), .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
        .wb_data(wb_data), .hold(hold), .flush(flush),
        .out_valid(out_valid), .out_opA(out_opA), .out_opB(out_opB),
        .out_rd(out_rd), .out_regWrite(out_regWrite), .out_memRead(out_memRead),
        .id_stall(id_stall), .stall_count(stall_count)
    );

    operand_forward_stage #(.CNT_WIDTH(4)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_regWrite(in_regWrite), .in_memRead(in_memRead),
        .in_rf_data1(in_rf_data1), .in_rf_data2(in_rf_data2),
        .ex_result(ex_result), .mem_rd(mem_rd), .mem_regWrite(mem_regWrite),
        .mem_result(mem_result), .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
        .wb_data(wb_data), .hold(hold), .flush(flush),
        .out_valid(s_valid), .out_opA(s_opA), .out_opB(s_opB),
        .out_rd(s_rd), .out_regWrite(s_regWrite), .out_memRead(s_memRead),
        .id_stall(s_id_stall), .stall_count(s_stall_count)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 0; in_regWrite = 0; in_memRead = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rf_data1 = 0; in_rf_data2 = 0; ex_result = 0;
        mem_rd = 0; mem_regWrite = 0; mem_result = 0;
        wb_rd = 0; wb_regWrite = 0; wb_data = 0;
        hold = 0; flush = 0;
    endtask

    task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic rw, input logic mr);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_regWrite = rw; in_memRead = mr;
    endtask

    task automatic load_ex(input logic [4:0] rd);
        drive_instr(5'd0, 5'd0, rd, 1'b1, 1'b1);
        step;
    endtask

    task automatic test_reset;
        idle_inputs;
        step;
        reset = 0;
        drive_instr(5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        in_rf_data1 = 64'h55; in_rf_data2 = 64'h66;
        step;
        #3 reset = 1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h expected 0", out_valid); end
        n_cmp++; if (out_opA !== 64'h0) begin n_err++; $display("FAIL rst_opA: got %0h expected 0", out_opA); end
        n_cmp++; if (out_opB !== 64'h0) begin n_err++; $display("FAIL rst_opB: got %0h expected 0", out_opB); end
        n_cmp++; if (out_rd !== 5'd0) begin n_err++; $display("FAIL rst_rd: got %0h expected 0", out_rd); end
        n_cmp++; if (out_regWrite !== 1'b0 || out_memRead !== 1'b0) begin n_err++; $display("FAIL rst_ctrl: got rw=%0b mr=%0b expected 0/0", out_regWrite, out_memRead); end
        n_cmp++; if (stall_count !== 16'h0) begin n_err++; $display("FAIL rst_count: got %0h expected 0", stall_count); end
        drive_instr(5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
        in_rf_data1 = 64'h11; in_rf_data2 = 64'h22;
        reset = 0;
        step;
        n_cmp++; if (out_opA !== 64'h11) begin n_err++; $display("FAIL first_opA: got %0h expected 11", out_opA); end
        n_cmp++; if (out_opB !== 64'h22) begin n_err++; $display("FAIL first_opB: got %0h expected 22", out_opB); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %0h expected 1", out_valid); end
    endtask

    task automatic test_forward;
        idle_inputs;
        drive_instr(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        step;
        drive_instr(5'd5, 5'd2, 5'd6, 1'b0, 1'b0);
        in_rf_data1 = 64'h99; in_rf_data2 = 64'h77;
        ex_result = 64'hAA;
        mem_rd = 5'd5; mem_regWrite = 1; mem_result = 64'hBB;
        wb_rd = 5'd5; wb_regWrite = 1; wb_data = 64'hCC;
        step;
        n_cmp++; if (out_opA !== 64'hAA) begin n_err++; $display("FAIL fwd_ex: got %0h expected aa", out_opA); end
        n_cmp++; if (out_opB !== 64'h77) begin n_err++; $display("FAIL fwd_rf2: got %0h expected 77", out_opB); end
        step;
        n_cmp++; if (out_opA !== 64'hBB) begin n_err++; $display("FAIL fwd_mem: got %0h expected bb", out_opA); end
        mem_regWrite = 0;
        in_rs2 = 5'd5;
        step;
        n_cmp++; if (out_opA !== 64'hCC) begin n_err++; $display("FAIL fwd_wb: got %0h expected cc", out_opA); end
        n_cmp++; if (out_opB !== 64'hCC) begin n_err++; $display("FAIL fwd_wb_b: got %0h expected cc", out_opB); end
        wb_regWrite = 0;
        step;
        n_cmp++; if (out_opA !== 64'h99 || out_opB !== 64'h77) begin n_err++; $display("FAIL fwd_none: got %0h/%0h expected 99/77", out_opA, out_opB); end
    endtask

    task automatic test_xzr;
        idle_inputs;
        drive_instr(5'd0, 5'd0, 5'd31, 1'b1, 1'b0);
        step;
        drive_instr(5'd31, 5'd9, 5'd1, 1'b0, 1'b0);
        in_rf_data1 = 64'h1111; in_rf_data2 = 64'h2222;
        ex_result = 64'hF00D;
        mem_rd = 5'd31; mem_regWrite = 1; mem_result = 64'hBEEF;
        wb_rd = 5'd31; wb_regWrite = 1; wb_data = 64'hDEAD;
        step;
        n_cmp++; if (out_opA !== 64'h0) begin n_err++; $display("FAIL xzr_opA: got %0h expected 0", out_opA); end
        n_cmp++; if (out_opB !== 64'h2222) begin n_err++; $display("FAIL xzr_opB: got %0h expected 2222", out_opB); end
    endtask

    task automatic test_load_use;
        idle_inputs;
        load_ex(5'd7);
        n_cmp++; if (out_memRead !== 1'b1 || out_rd !== 5'd7) begin n_err++; $display("FAIL lu_load: got mr=%0b rd=%0d expected 1/7", out_memRead, out_rd); end
        drive_instr(5'd1, 5'd7, 5'd8, 1'b1, 1'b0);
        in_rf_data1 = 64'h10; in_rf_data2 = 64'h5555;
        #1;
        n_cmp++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0b expected 1", id_stall); end
        step;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got %0b expected 0", out_valid); end
        n_cmp++; if (stall_count !== 16'd1) begin n_err++; $display("FAIL lu_count: got %0d expected 1", stall_count); end
        mem_rd = 5'd7; mem_regWrite = 1; mem_result = 64'h1234;
        #1;
        n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL lu_release: got %0b expected 0", id_stall); end
        step;
        n_cmp++; if (out_opB !== 64'h1234 || out_opA !== 64'h10) begin n_err++; $display("FAIL lu_fwd: got %0h/%0h expected 10/1234", out_opA, out_opB); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lu_valid: got %0b expected 1", out_valid); end
    endtask

    task automatic test_hold_flush;
        idle_inputs;
        load_ex(5'd7);
        drive_instr(5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
        hold = 1;
        #1;
        n_cmp++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL hold_stall: got %0b expected 1", id_stall); end
        step;
        n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_memRead !== 1'b1) begin n_err++; $display("FAIL hold_frozen: got v=%0b rd=%0d mr=%0b expected 1/7/1", out_valid, out_rd, out_memRead); end
        n_cmp++; if (stall_count !== 16'd1) begin n_err++; $display("FAIL hold_count: got %0d expected 1", stall_count); end
        flush = 1;
        #1;
        n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %0b expected 0", id_stall); end
        step;
        n_cmp++; if (out_valid !== 1'b0 || out_rd !== 5'd0) begin n_err++; $display("FAIL flush_bubble: got v=%0b rd=%0d expected 0/0", out_valid, out_rd); end
        n_cmp++; if (stall_count !== 16'd1) begin n_err++; $display("FAIL flush_count: got %0d expected 1", stall_count); end
    endtask

    task automatic test_boundaries;
        idle_inputs;
        load_ex(5'd7);
        drive_instr(5'd0, 5'd7, 5'd8, 1'b1, 1'b0);
        in_valid = 0;
        #1;
        n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL invalid_stall: got %0b expected 0", id_stall); end
        step;
        n_cmp++; if (out_valid !== 1'b0 || stall_count !== 16'd1) begin n_err++; $display("FAIL invalid_pass: got v=%0b cnt=%0d expected 0/1", out_valid, stall_count); end
        load_ex(5'd31);
        drive_instr(5'd31, 5'd31, 5'd2, 1'b1, 1'b0);
        #1;
        n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL xzr_load_stall: got %0b expected 0", id_stall); end
        step;
        n_cmp++; if (out_valid !== 1'b1 || stall_count !== 16'd1) begin n_err++; $display("FAIL xzr_load_pass: got v=%0b cnt=%0d expected 1/1", out_valid, stall_count); end
    endtask

    task automatic test_back_to_back;
        idle_inputs;
        reset = 1;
        #2 reset = 0;
        for (int i = 0; i < 15; i++) begin
            load_ex(5'd7);
            drive_instr(5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
            step;
        end
        n_cmp++; if (s_stall_count !== 4'hF) begin n_err++; $display("FAIL sat_reach: got %0h expected f", s_stall_count); end
        n_cmp++; if (stall_count !== 16'd15) begin n_err++; $display("FAIL count_15: got %0d expected 15", stall_count); end
        load_ex(5'd7);
        drive_instr(5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
        step;
        n_cmp++; if (s_stall_count !== 4'hF) begin n_err++; $display("FAIL sat_hold: got %0h expected f", s_stall_count); end
        n_cmp++; if (stall_count !== 16'd16) begin n_err++; $display("FAIL count_16: got %0d expected 16", stall_count); end
    endtask

    task automatic test_reset_mid_stall;
        idle_inputs;
        load_ex(5'd7);
        drive_instr(5'd0, 5'd7, 5'd8, 1'b1, 1'b0);
        #1;
        n_cmp++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL mid_pre_stall: got %0b expected 1", id_stall); end
        #2 reset = 1;
        #1;
        n_cmp++; if (stall_count !== 16'd0 || out_valid !== 1'b0 || out_memRead !== 1'b0) begin n_err++; $display("FAIL mid_reset: got cnt=%0d v=%0b mr=%0b expected 0/0/0", stall_count, out_valid, out_memRead); end
        n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL mid_stall_clr: got %0b expected 0", id_stall); end
        reset = 0;
        idle_inputs;
        step;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs;
        test_reset;
        test_forward;
        test_xzr;
        test_load_use;
        test_hold_flush;
        test_boundaries;
        test_back_to_back;
        test_reset_mid_stall;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
